// File: rtl/uart_rx_ext.sv
// uart_rx_ext: parametrised oversampling UART receiver with a one-entry holding register.
// Define UART_RX_PARITY_EN to compile in the parity bit and parity checking.
module uart_rx_ext #(
  parameter int DATA_BITS  = 8,
  parameter int OS_TICKS   = 16,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_tick,
  input  logic                 rx,
  input  logic                 rd_ack,
  output logic [DATA_BITS-1:0] d_out,
  output logic                 d_valid,
  output logic                 rx_done_tick,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int SW = $clog2(OS_TICKS * 2);
  localparam int NW = $clog2(DATA_BITS);
  localparam logic [SW-1:0] HalfLast = SW'(OS_TICKS / 2 - 1);
  localparam logic [SW-1:0] BitLast  = SW'(OS_TICKS - 1);
  localparam logic [NW-1:0] DataLast = NW'(DATA_BITS - 1);
  localparam logic [NW-1:0] StopLast = NW'(STOP_BITS - 1);

`ifdef UART_RX_PARITY_EN
  localparam logic OddParity = (PARITY_ODD != 0);
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} stateT;
`else
  typedef enum logic [2:0] {StIdle, StStart, StData, StStop} stateT;
`endif

  logic                 rxMeta, rxS;
  stateT                stateQ, stateD;
  logic [SW-1:0]        sCntQ, sCntD;
  logic [NW-1:0]        nCntQ, nCntD;
  logic [DATA_BITS-1:0] shiftQ, shiftD;
  logic                 ferrQ, ferrD;
  logic                 frameDone;
`ifdef UART_RX_PARITY_EN
  logic                 parBitQ, parBitD;
`endif

  logic [DATA_BITS-1:0] dOutD;
  logic                 dValidD, doneD, frameErrD, parityErrD, overrunD, busyD;

  // State register: synchronizer, FSM datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rxMeta       <= 1'b1;
      rxS          <= 1'b1;
      stateQ       <= StIdle;
      sCntQ        <= '0;
      nCntQ        <= '0;
      shiftQ       <= '0;
      ferrQ        <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parBitQ      <= 1'b0;
`endif
      d_out        <= '0;
      d_valid      <= 1'b0;
      rx_done_tick <= 1'b0;
      frame_err    <= 1'b0;
      parity_err   <= 1'b0;
      overrun      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      rxMeta       <= rx;
      rxS          <= rxMeta;
      stateQ       <= stateD;
      sCntQ        <= sCntD;
      nCntQ        <= nCntD;
      shiftQ       <= shiftD;
      ferrQ        <= ferrD;
`ifdef UART_RX_PARITY_EN
      parBitQ      <= parBitD;
`endif
      d_out        <= dOutD;
      d_valid      <= dValidD;
      rx_done_tick <= doneD;
      frame_err    <= frameErrD;
      parity_err   <= parityErrD;
      overrun      <= overrunD;
      busy         <= busyD;
    end
  end

  // Next-state logic; counters only move on s_tick.
  always_comb begin
    stateD    = stateQ;
    sCntD     = sCntQ;
    nCntD     = nCntQ;
    shiftD    = shiftQ;
    ferrD     = ferrQ;
    frameDone = 1'b0;
`ifdef UART_RX_PARITY_EN
    parBitD   = parBitQ;
`endif
    unique case (stateQ)
      StIdle: begin
        if (!rxS) begin
          sCntD  = '0;
          stateD = StStart;
        end
      end
      StStart: begin
        if (s_tick) begin
          if (sCntQ == HalfLast) begin
            if (!rxS) begin
              sCntD  = '0;
              nCntD  = '0;
              ferrD  = 1'b0;
              stateD = StData;
            end else begin
              stateD = StIdle;
            end
          end else begin
            sCntD = sCntQ + 1'b1;
          end
        end
      end
      StData: begin
        if (s_tick) begin
          if (sCntQ == BitLast) begin
            sCntD  = '0;
            shiftD = {rxS, shiftQ[DATA_BITS-1:1]};
            if (nCntQ == DataLast) begin
              nCntD  = '0;
`ifdef UART_RX_PARITY_EN
              stateD = StParity;
`else
              stateD = StStop;
`endif
            end else begin
              nCntD = nCntQ + 1'b1;
            end
          end else begin
            sCntD = sCntQ + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (s_tick) begin
          if (sCntQ == BitLast) begin
            parBitD = rxS;
            sCntD   = '0;
            stateD  = StStop;
          end else begin
            sCntD = sCntQ + 1'b1;
          end
        end
      end
`endif
      StStop: begin
        // nCnt is reused to count stop samples; leaving at mid-stop allows resync.
        if (s_tick) begin
          if (sCntQ == BitLast) begin
            sCntD = '0;
            if (!rxS) ferrD = 1'b1;
            if (nCntQ == StopLast) begin
              nCntD     = '0;
              frameDone = 1'b1;
              stateD    = StIdle;
            end else begin
              nCntD = nCntQ + 1'b1;
            end
          end else begin
            sCntD = sCntQ + 1'b1;
          end
        end
      end
      default: stateD = StIdle;
    endcase
  end

  // Output logic: holding register, error flags and read handshake.
  always_comb begin
    dOutD      = d_out;
    dValidD    = d_valid;
    frameErrD  = frame_err;
    parityErrD = parity_err;
    overrunD   = overrun;
    doneD      = frameDone;
    busyD      = (stateD != StIdle);
    if (rd_ack && d_valid) begin
      dValidD  = 1'b0;
      overrunD = 1'b0;
    end
    if (frameDone) begin
      dOutD     = shiftQ;
      dValidD   = 1'b1;
      frameErrD = ferrD;
`ifdef UART_RX_PARITY_EN
      parityErrD = (^shiftQ) ^ parBitQ ^ OddParity;
`else
      parityErrD = 1'b0;
`endif
      if (d_valid && !rd_ack) overrunD = 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_rx_ext.sv
// Bench for uart_rx_ext: frame-level model predicts completion cycles and holding-register state.
`timescale 1ns/1ps
module tb_uart_rx_ext;

  localparam int OS = 16;
`ifdef UART_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int BITCYC = 2 * OS;  // s_tick fires on every even cycle

  logic clk = 1'b0, reset = 1'b0, sTick = 1'b0, rx = 1'b1, rdAck = 1'b0;
  logic [7:0] dOut;
  logic dValid, doneTick, frameErr, parityErr, overrun, busy;
  logic reset5 = 1'b0, rx5 = 1'b1, rdAck5 = 1'b0;
  logic [4:0] dOut5;
  logic dValid5, doneTick5, frameErr5, parityErr5, overrun5, busy5;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit cmpEn = 1'b0;

  uart_rx_ext #(.DATA_BITS(8), .OS_TICKS(OS), .STOP_BITS(1), .PARITY_ODD(0)) dut (
    .clk(clk), .reset(reset), .s_tick(sTick), .rx(rx), .rd_ack(rdAck), .d_out(dOut),
    .d_valid(dValid), .rx_done_tick(doneTick), .frame_err(frameErr), .parity_err(parityErr),
    .overrun(overrun), .busy(busy)
  );

  uart_rx_ext #(.DATA_BITS(5), .OS_TICKS(OS), .STOP_BITS(2), .PARITY_ODD(0)) dut5 (
    .clk(clk), .reset(reset5), .s_tick(sTick), .rx(rx5), .rd_ack(rdAck5), .d_out(dOut5),
    .d_valid(dValid5), .rx_done_tick(doneTick5), .frame_err(frameErr5),
    .parity_err(parityErr5), .overrun(overrun5), .busy(busy5)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    sTick = (cyc % 2 == 0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Model: a frame either completes at its predicted cycle or not at all.
  typedef struct {int at; logic [7:0] data; bit ferr; bit perr;} expT;
  expT expQ[$];
  logic [7:0] mDout = '0;
  bit mValid = 0, mDone = 0, mFerr = 0, mPerr = 0, mOvr = 0, mHit = 0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    mHit = (expQ.size() > 0) && (expQ[0].at == cyc);
    mDone = 1'b0;
    if (!reset) begin
      mDout = '0; mValid = 0; mFerr = 0; mPerr = 0; mOvr = 0;
      expQ.delete();
    end else if (mHit) begin
      mDone = 1'b1;
      mOvr = (mValid && !rdAck) ? 1'b1 : ((mValid && rdAck) ? 1'b0 : mOvr);
      mValid = 1'b1;
      mDout = expQ[0].data;
      mFerr = expQ[0].ferr;
      mPerr = expQ[0].perr;
      void'(expQ.pop_front());
    end else if (rdAck && mValid) begin
      mValid = 1'b0;
      mOvr = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (cmpEn) begin
      chk("d_out", dOut, mDout);
      chk("d_valid", dValid, mValid);
      chk("rx_done_tick", doneTick, mDone);
      chk("frame_err", frameErr, mFerr);
      chk("parity_err", parityErr, mPerr);
      chk("overrun", overrun, mOvr);
    end
  end

  // Drives one frame on the main line cycle by cycle; optionally pulses rd_ack on completion.
  task automatic sendMain(input logic [7:0] data, input bit badStop, input bit parFlip,
                          input bit ackAtDone);
    logic [15:0] bits;
    int nb, k, t1, at;
    bit perr;
    nb = 1 + 8 + PB + 1;
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = data[i];
    perr = 1'b0;
    if (PB == 1) begin
      bits[9] = (^data) ^ parFlip;
      perr = (^data) ^ bits[9];
    end
    bits[nb-1] = !badStop;
    k = cyc;
    t1 = ((k + 3) % 2 == 0) ? k + 3 : k + 4;
    at = t1 + 2 * (OS / 2 + OS * (8 + PB + 1) - 1) + 1;
    expQ.push_back('{at, data, badStop, perr});
    for (int off = 0; off < nb * BITCYC + 48; off++) begin
      int b;
      b = off / BITCYC;
      rx = (b < nb) ? bits[b] : 1'b1;
      // Release a low stop bit early so the mid-stop restart sees an idle line.
      if (badStop && b == nb - 1 && (off % BITCYC) >= 24) rx = 1'b1;
      rdAck = ackAtDone && (cyc == at - 1);
      @(posedge clk); #1;
    end
    rdAck = 1'b0;
  endtask

  task automatic ackPulse();
    rdAck = 1'b1;
    @(posedge clk); #1;
    rdAck = 1'b0;
  endtask

  // Frame for the 5-bit/2-stop instance; abortOff >= 0 pulses reset at that offset.
  task automatic sendD5(input logic [4:0] data, input bit badStop2, input int abortOff,
                        output int doneCnt);
    logic [15:0] bits;
    int nb;
    bit aborted;
    nb = 1 + 5 + PB + 2;
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 5; i++) bits[1+i] = data[i];
    if (PB == 1) bits[6] = ^data;
    bits[nb-1] = !badStop2;
    doneCnt = 0;
    aborted = 1'b0;
    for (int off = 0; off < nb * BITCYC + 48; off++) begin
      int b;
      b = off / BITCYC;
      rx5 = (b < nb && !aborted) ? bits[b] : 1'b1;
      if (badStop2 && b == nb - 1 && (off % BITCYC) >= 24) rx5 = 1'b1;
      reset5 = (off == abortOff) ? 1'b0 : 1'b1;
      if (off == abortOff) begin
        aborted = 1'b1;
        rx5 = 1'b1;
      end
      @(posedge clk); #1;
      if (doneTick5) doneCnt++;
      if (off == abortOff) begin
        chk("abort_d_out", dOut5, 5'h00);
        chk("abort_d_valid", dValid5, 0);
        chk("abort_done", doneTick5, 0);
        chk("abort_frame_err", frameErr5, 0);
        chk("abort_parity_err", parityErr5, 0);
        chk("abort_overrun", overrun5, 0);
        chk("abort_busy", busy5, 0);
      end
    end
    reset5 = 1'b1;
  endtask

  initial begin
    int busySeen;
    int cnt5;
    reset = 1'b0;
    reset5 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_d_out", dOut, 8'h00);
    chk("rst_d_valid", dValid, 0);
    chk("rst_done", doneTick, 0);
    chk("rst_frame_err", frameErr, 0);
    chk("rst_parity_err", parityErr, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_busy", busy, 0);
    cmpEn = 1'b1;
    reset = 1'b1;
    reset5 = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    sendMain(8'hA5, 0, 0, 0);
    chk("a5_d_out", dOut, 8'hA5);
    chk("a5_d_valid", dValid, 1);
    chk("a5_frame_err", frameErr, 0);
    chk("a5_parity_err", parityErr, 0);
    chk("a5_overrun", overrun, 0);
    ackPulse();
    chk("a5_ack_d_valid", dValid, 0);

    busySeen = 0;
    for (int i = 0; i < 80; i++) begin
      rx = (i < 8) ? 1'b0 : 1'b1;
      @(posedge clk); #1;
      if (busy) busySeen++;
    end
    chk("glitch_busy_seen", busySeen != 0, 1);
    chk("glitch_busy_end", busy, 0);
    chk("glitch_d_valid", dValid, 0);

    sendMain(8'h3C, 1, 0, 0);
    chk("3c_d_out", dOut, 8'h3C);
    chk("3c_frame_err", frameErr, 1);
    ackPulse();
    sendMain(8'h42, 0, 0, 0);
    chk("42_d_out", dOut, 8'h42);
    chk("42_frame_err", frameErr, 0);
    ackPulse();

    sendMain(8'h11, 0, 0, 0);
    sendMain(8'h22, 0, 0, 0);
    chk("ovr_d_out", dOut, 8'h22);
    chk("ovr_overrun", overrun, 1);
    chk("ovr_d_valid", dValid, 1);
    ackPulse();
    chk("ovr_ack_d_valid", dValid, 0);
    chk("ovr_ack_overrun", overrun, 0);

    sendMain(8'h33, 0, 0, 0);
    sendMain(8'h5A, 0, 0, 1);
    chk("sim_d_out", dOut, 8'h5A);
    chk("sim_d_valid", dValid, 1);
    chk("sim_overrun", overrun, 0);
    ackPulse();

`ifdef UART_RX_PARITY_EN
    sendMain(8'h07, 0, 1, 0);
    chk("par0_parity_err", parityErr, 1);
    ackPulse();
    sendMain(8'h07, 0, 0, 0);
    chk("par1_parity_err", parityErr, 0);
    ackPulse();
`endif

    sendD5(5'h15, 1, -1, cnt5);
    chk("d5_done_count", cnt5, 1);
    chk("d5_d_out", dOut5, 5'h15);
    chk("d5_frame_err", frameErr5, 1);
    chk("d5_d_valid", dValid5, 1);
    sendD5(5'h0A, 0, BITCYC * 3 + 10, cnt5);
    chk("d5_abort_done_count", cnt5, 0);
    chk("d5_abort_d_valid", dValid5, 0);

    chk("pending_frames", expQ.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule
